// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the 8-bit CPU sequencer: FSM state encoding, opcode
// constants and the control-transfer decision.
package cpu_sequencer_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [3:0] OP_J   = 4'b1000;
   localparam logic [3:0] OP_JAL = 4'b1001;
   localparam logic [3:0] OP_LW  = 4'b1010;
   localparam logic [3:0] OP_SW  = 4'b1011;
   localparam logic [3:0] OP_BEQ = 4'b1100;
   localparam logic [3:0] OP_BNE = 4'b1101;

   // Unconditional jumps always transfer; branches depend on the ALU zero flag.
   function automatic logic branch_taken(input logic [3:0] op, input logic zero);
      return (op == OP_BEQ && zero) || (op == OP_BNE && !zero) ||
             (op == OP_J) || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction- and data-memory handshake bundle. The sequencer is the
// master (drives requests and address); the memories are the slave.
interface cpu_sequencer_if #(
   parameter int PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [7:0]      imem_rdata;
   logic            dmem_req;
   logic            dmem_we;
   logic            dmem_ack;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we,
      input  imem_ack, imem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we,
      output imem_ack, imem_rdata, dmem_ack
   );
endinterface

// File: rtl/cpu_sequencer_perf.sv
// Saturating cycle / retired-instruction counters. Compiled only when
// CPU_SEQ_PERF_EN is defined.
`ifdef CPU_SEQ_PERF_EN
module cpu_perf_counters (
   input  logic        clk,
   input  logic        reset,
   input  logic        cyc_inc,
   input  logic        instr_inc,
   output logic [15:0] cyc_cnt,
   output logic [15:0] instr_cnt
);
   // Both counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_cnt   <= '0;
         instr_cnt <= '0;
      end else begin
         if (cyc_inc && cyc_cnt != 16'hFFFF)
            cyc_cnt <= cyc_cnt + 16'd1;
         if (instr_inc && instr_cnt != 16'hFFFF)
            instr_cnt <= instr_cnt + 16'd1;
      end
   end
endmodule
`endif

// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer for the 8-bit CPU: owns PC and instruction register
// and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
// Optional macro CPU_SEQ_PERF_EN adds cyc_cnt / instr_cnt outputs.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   cpu_sequencer_if.master bus,
   output logic [7:0]      instr_q,
   input  logic [7:0]      dec_jump,
   input  logic            dec_mem_w_en,
   input  logic            dec_reg_w_en,
   input  logic            dec_sel_w_src,
   input  logic            alu_zero,
   input  logic [PC_W-1:0] jump_target,
   output logic            reg_w_strobe,
   output logic [PC_W-1:0] pc,
   input  logic            halt_req,
   output logic            halted
`ifdef CPU_SEQ_PERF_EN
   ,
   output logic [15:0]     cyc_cnt,
   output logic [15:0]     instr_cnt
`endif
);

   state_t state;
   logic   take;
   logic   go_mem;
   logic   go_wb;
   logic   fetch_done;
   logic   mem_done;
   logic   instr_done;

   assign bus.imem_addr = pc;

   // Control-transfer decision, handshake completions and instruction boundary.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      instr_done = 1'b0;
      take       = (|dec_jump) && branch_taken(instr_q[7:4], alu_zero);
      go_mem     = dec_mem_w_en | dec_sel_w_src;
      go_wb      = dec_reg_w_en;
      fetch_done = bus.imem_req & bus.imem_ack;
      mem_done   = bus.dmem_req & bus.dmem_ack;
      case (state)
         S_EXEC:  instr_done = !go_mem && !go_wb;
         S_MEM:   instr_done = mem_done && !dec_sel_w_src;
         S_WB:    instr_done = 1'b1;
         default: instr_done = 1'b0;
      endcase
   end

   // Sequencer FSM with registered requests and strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_FETCH;
         pc           <= RESET_PC;
         instr_q      <= '0;
         bus.imem_req <= 1'b0;
         bus.dmem_req <= 1'b0;
         bus.dmem_we  <= 1'b0;
         reg_w_strobe <= 1'b0;
         halted       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments; later ones in this block win, so the
         // per-state case below only overrides when the instruction continues.
         reg_w_strobe <= 1'b0;
         if (instr_done) begin
            if (halt_req) begin
               state  <= S_HALT;
               halted <= 1'b1;
            end else begin
               state        <= S_FETCH;
               bus.imem_req <= 1'b1;
            end
         end
         case (state)
            S_FETCH: begin
               if (fetch_done) begin
                  instr_q      <= bus.imem_rdata;
                  bus.imem_req <= 1'b0;
                  state        <= S_DECODE;
               end else begin
                  // Raises the request in the first cycle after reset.
                  bus.imem_req <= 1'b1;
               end
            end
            S_DECODE: state <= S_EXEC;
            S_EXEC: begin
               pc <= take ? jump_target : pc + 1'b1;
               if (go_mem) begin
                  state        <= S_MEM;
                  bus.dmem_req <= 1'b1;
                  bus.dmem_we  <= dec_mem_w_en;
               end else if (go_wb) begin
                  state        <= S_WB;
                  reg_w_strobe <= 1'b1;
               end
            end
            S_MEM: begin
               if (mem_done) begin
                  bus.dmem_req <= 1'b0;
                  if (dec_sel_w_src) begin
                     state        <= S_WB;
                     reg_w_strobe <= 1'b1;
                  end
               end
            end
            S_WB: ;
            S_HALT: begin
               if (!halt_req) begin
                  state        <= S_FETCH;
                  halted       <= 1'b0;
                  bus.imem_req <= 1'b1;
               end
            end
            default: state <= S_FETCH;
         endcase
      end
   end

`ifdef CPU_SEQ_PERF_EN
   cpu_perf_counters u_perf (
      .clk       (clk),
      .reset     (reset),
      .cyc_inc   (state != S_HALT),
      .instr_inc (instr_done),
      .cyc_cnt   (cyc_cnt),
      .instr_cnt (instr_cnt)
   );
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: the driver plays decoder, datapath and
// both memories, a transaction-level model predicts every handshake, strobe
// and halt with its cycle, and a monitor compares what the DUT presents.
module tb_cpu_sequencer;
   import cpu_sequencer_pkg::*;

   localparam int EV_FETCH = 1;
   localparam int EV_DMEM  = 2;
   localparam int EV_WB    = 3;
   localparam int EV_HALT  = 4;

   typedef struct {
      int kind;
      int val;
      int cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] instr_q;
   logic [7:0] dec_jump;
   logic       dec_mem_w_en, dec_reg_w_en, dec_sel_w_src;
   logic       alu_zero;
   logic [7:0] jump_target;
   logic       reg_w_strobe;
   logic [7:0] pc;
   logic       halt_req;
   logic       halted;
`ifdef CPU_SEQ_PERF_EN
   logic [15:0] cyc_cnt, instr_cnt;
`endif

   cpu_sequencer_if #(.PC_W(8)) bus ();

   cpu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .instr_q       (instr_q),
      .dec_jump      (dec_jump),
      .dec_mem_w_en  (dec_mem_w_en),
      .dec_reg_w_en  (dec_reg_w_en),
      .dec_sel_w_src (dec_sel_w_src),
      .alu_zero      (alu_zero),
      .jump_target   (jump_target),
      .reg_w_strobe  (reg_w_strobe),
      .pc            (pc),
      .halt_req      (halt_req),
      .halted        (halted)
`ifdef CPU_SEQ_PERF_EN
      ,
      .cyc_cnt       (cyc_cnt),
      .instr_cnt     (instr_cnt)
`endif
   );

   always #5 clk = ~clk;

   int  cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;
   ev_t exp_q[$];
   int  exp_start;
   logic [7:0] exp_pc;
   int  exp_done;
   logic halted_d = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Combinational instruction decoder as seen by the sequencer.
   always_comb begin
      dec_jump      = 8'h00;
      dec_mem_w_en  = 1'b0;
      dec_reg_w_en  = 1'b0;
      dec_sel_w_src = 1'b0;
      case (instr_q[7:4])
         OP_J, OP_BEQ, OP_BNE: dec_jump = 8'h01;
         OP_JAL: begin dec_jump = 8'h02; dec_reg_w_en = 1'b1; end
         OP_LW:  begin dec_sel_w_src = 1'b1; dec_reg_w_en = 1'b1; end
         OP_SW:  dec_mem_w_en = 1'b1;
         4'b1110, 4'b1111: ;
         default: dec_reg_w_en = 1'b1;
      endcase
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic longint pack(input int k, input int v, input int c);
      return (longint'(k) << 48) | (longint'(v & 16'hFFFF) << 32) | longint'(c);
   endfunction

   task automatic got(input int k, input int v);
      ev_t e;
      if (exp_q.size() == 0) begin
         check("unexpected_event{kind,val,cyc}", pack(k, v, cyc), 0);
      end else begin
         e = exp_q.pop_front();
         check("event{kind,val,cyc}", pack(k, v, cyc), pack(e.kind, e.val, e.cyc));
      end
   endtask

   // Monitor: every handshake, strobe and halt entry is matched against the model.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.imem_req && bus.imem_ack) got(EV_FETCH, int'(bus.imem_addr));
         if (bus.dmem_req && bus.dmem_ack) got(EV_DMEM, int'(bus.dmem_we));
         if (reg_w_strobe)                 got(EV_WB, 1);
         if (halted && !halted_d) begin
            got(EV_HALT, int'(pc));
`ifdef CPU_SEQ_PERF_EN
            check("instr_cnt_at_halt", longint'(instr_cnt), longint'(exp_done));
`endif
         end
         if (halted) check("imem_req_while_halted", longint'(bus.imem_req), 0);
      end
      halted_d = halted;
   end

   task automatic wait_imem_req();
      for (int i = 0; i < 100 && !bus.imem_req; i++) begin @(posedge clk); #1; end
      check("imem_req_seen", longint'(bus.imem_req), 1);
   endtask

   task automatic wait_dmem_req();
      for (int i = 0; i < 100 && !bus.dmem_req; i++) begin @(posedge clk); #1; end
      check("dmem_req_seen", longint'(bus.dmem_req), 1);
   endtask

   // Predict one instruction's transactions, then play the environment for it.
   task automatic run_instr(input logic [7:0] ins, input int fw, input int mw,
                            input logic zero, input logic [7:0] tgt,
                            input bit do_halt, input int hold);
      logic [3:0] op;
      logic [7:0] npc;
      bit is_ld, is_st, writes, taken;
      int s, t;
      op     = ins[7:4];
      is_ld  = (op == OP_LW);
      is_st  = (op == OP_SW);
      writes = (op < 4'd8) || (op == OP_JAL) || is_ld;
      taken  = (op == OP_J) || (op == OP_JAL) ||
               (op == OP_BEQ && zero) || (op == OP_BNE && !zero);
      npc    = taken ? tgt : exp_pc + 8'd1;
      s      = exp_start;
      exp_q.push_back('{EV_FETCH, int'(exp_pc), s + fw});
      t = s + fw + 3;
      if (is_ld || is_st) begin
         exp_q.push_back('{EV_DMEM, int'(is_st), t + mw});
         t = t + mw + 1;
      end
      if (writes) begin
         exp_q.push_back('{EV_WB, 1, t});
         t = t + 1;
      end
      if (exp_done < 65535) exp_done++;
      if (do_halt) exp_q.push_back('{EV_HALT, int'(npc), t});

      wait_imem_req();
      repeat (fw) begin @(posedge clk); #1; end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = ins;
      alu_zero       = zero;
      jump_target    = tgt;
      @(posedge clk); #1;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 8'($urandom);
      if (do_halt) begin
         @(posedge clk); #1;
         halt_req = 1'b1;
      end
      if (is_ld || is_st) begin
         wait_dmem_req();
         repeat (mw) begin @(posedge clk); #1; end
         bus.dmem_ack = 1'b1;
         @(posedge clk); #1;
         bus.dmem_ack = 1'b0;
      end
      exp_pc = npc;
      if (do_halt) begin
         while (cyc < t + hold) begin @(posedge clk); #1; end
         halt_req  = 1'b0;
         exp_start = t + hold + 1;
      end else begin
         exp_start = t;
      end
   endtask

   task automatic check_reset_state();
      check("rst_pc", longint'(pc), 0);
      check("rst_instr_q", longint'(instr_q), 0);
      check("rst_imem_req", longint'(bus.imem_req), 0);
      check("rst_dmem_req", longint'(bus.dmem_req), 0);
      check("rst_reg_w_strobe", longint'(reg_w_strobe), 0);
      check("rst_halted", longint'(halted), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      halt_req       = 1'b0;
      alu_zero       = 1'b0;
      jump_target    = 8'h00;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 8'h00;
      bus.dmem_ack   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      reset     = 1'b0;
      exp_start = cyc + 1;
      exp_pc    = 8'h00;
      exp_done  = 0;

      // Directed: add, beq taken / not taken, slow lw, sw, jump to FF then wrap, halt.
      run_instr(8'h15, 0, 0, 1'b0, 8'h00, 1'b0, 0);
      run_instr(8'hC0, 0, 0, 1'b1, 8'h40, 1'b0, 0);
      run_instr(8'hC0, 1, 0, 1'b0, 8'h77, 1'b0, 0);
      run_instr(8'hA4, 0, 3, 1'b0, 8'h00, 1'b0, 0);
      run_instr(8'hB4, 0, 1, 1'b0, 8'h00, 1'b0, 0);
      run_instr(8'h80, 0, 0, 1'b0, 8'hFF, 1'b0, 0);
      run_instr(8'hE0, 2, 0, 1'b1, 8'h33, 1'b0, 0);
      run_instr(8'h12, 0, 0, 1'b0, 8'h00, 1'b1, 3);
      run_instr(8'hD0, 0, 0, 1'b1, 8'h55, 1'b0, 0);

      // Reset while a fetch is pending; a late ack right after must be ignored.
      wait_imem_req();
      check("queue_drained_before_reset", longint'(exp_q.size()), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_state();
      reset          = 1'b0;
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 8'hA0;
      exp_start      = cyc + 1;
      exp_pc         = 8'h00;
      exp_done       = 0;
      @(posedge clk); #1;
      bus.imem_ack   = 1'b0;

      run_instr(8'h12, 0, 0, 1'b0, 8'h00, 1'b1, 1);

      // Randomised instruction stream with random handshake delays and halts.
      for (int i = 0; i < 40; i++) begin
         run_instr(8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                   1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0),
                   $urandom_range(1, 3));
      end

      repeat (10) @(posedge clk);
      #1;
      check("queue_drained_at_end", longint'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
